mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter between the CPU's instruction fetch unit (IFU) and load/store unit (LSU). It sits between `cpu` and the unified instruction/data memory. It grants one requester per transaction with round-robin fairness and tracks the memory's fixed read latency. It routes each response back to the requester that owns the transaction.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, data width; must be a multiple of 8
- `LATENCY`, 1, cycles from `mem_en` to valid `mem_rdata`; must be 1..15
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `ifu_req`  in  1  IFU read request
- `ifu_addr`  in  ADDR_WIDTH  IFU address
- `ifu_gnt`  out  1  IFU request accepted this cycle
- `ifu_rvalid`  out  1  IFU read data valid
- `ifu_rdata`  out  DATA_WIDTH  IFU read data
- `lsu_req`  in  1  LSU request
- `lsu_we`  in  1  LSU write (1) or read (0)
- `lsu_addr`  in  ADDR_WIDTH  LSU address
- `lsu_wdata`  in  DATA_WIDTH  LSU write data
- `lsu_wstrb`  in  DATA_WIDTH/8  LSU byte strobes
- `lsu_gnt`  out  1  LSU request accepted this cycle
- `lsu_rvalid`  out  1  LSU response (read data or write ack)
- `lsu_rdata`  out  DATA_WIDTH  LSU read data
- `mem_en`  out  1  memory access this cycle
- `mem_we`  out  DATA_WIDTH/8  byte write enables
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_wdata`  out  DATA_WIDTH  memory write data
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid `LATENCY` cycles after `mem_en`

## Operation
- State machine has two states.
  - IDLE: can accept a request.
  - BUSY: a transaction is outstanding; a down-counter `cnt` holds the remaining cycles.
- Registered `owner` bit records who owns the outstanding transaction (0 = IFU, 1 = LSU).
- Registered `last` bit records the last granted requester. Reset value of `last` is IFU, so the LSU wins the first tie.
- Grant is combinational. It can occur only when `accept = (state==IDLE) || (state==BUSY && cnt==1)`, and never while `rst` is high.
  - Only one requester asserted: that requester is granted.
  - Both asserted: the requester that is not `last` is granted.
- In a grant cycle:
  - `mem_en` = 1.
  - `mem_addr` is taken from the granted requester.
  - On an LSU write, `mem_we` = `lsu_wstrb` and `mem_wdata` = `lsu_wdata`.
  - Otherwise `mem_we` = 0 and `mem_wdata` = 0.
- In any non-grant cycle, `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are all 0.
- On a grant, the next state is BUSY with `cnt` = `LATENCY`. `owner` and `last` are set to the granted requester.
- In BUSY with no grant, `cnt` decrements each cycle. When `cnt` reaches 1 and there is no new grant, the next state is IDLE.
- Response: while `state==BUSY && cnt==1`, the owner's `rvalid` = 1 and its `rdata` = `mem_rdata`.
  - The non-owner's `rvalid` is 0 and its `rdata` is 0.
  - Writes also produce `lsu_rvalid`; `lsu_rdata` is don't-care on write acks but is still driven from `mem_rdata`.
- Requester obligations:
  - Hold `req` and all request fields stable until `gnt`.
  - Dropping `req` before `gnt` withdraws the request.
  - After `gnt`, the requester may change its fields or issue the next request immediately.
- Reset (any cycle, including mid-transaction):
  - Next state is IDLE, `cnt`=0, `owner`=0, `last`=IFU.
  - The pending response is discarded; no `rvalid` is issued for it.
  - During the `rst` cycle every output is 0.

## Timing
- Grant cycle T: `mem_en` is high in T and the response `rvalid` is high in T+`LATENCY`, exactly one cycle wide.
- Back-to-back: a new grant may occur in the same cycle as the previous response. Peak throughput is one transaction per `LATENCY` cycles.
- With `LATENCY`=1, grants may occur every cycle and the arbiter alternates IFU/LSU under continuous contention.
- No combinational path from `mem_rdata` to any grant or memory-side output.
- Width rules:
  - `cnt` is 4 bits.
  - `mem_we` width is DATA_WIDTH/8.
  - Addresses pass through unmodified; no alignment check.

## Test plan
- **Reset state:** hold `rst`=1 for 2 cycles with both `req`=1. All outputs must be 0. After release, the LSU is granted first.
- **Single read, `LATENCY`=2:** IFU requests addr 0x0000_0010 at cycle T. Expect `ifu_gnt`, `mem_en`=1, `mem_addr`=0x10 and `mem_we`=0 at T. At T+2, `ifu_rvalid`=1, `ifu_rdata` equals memory word 0x10, and `lsu_rvalid`=0.
- **LSU byte write, `LATENCY`=2:** `lsu_we`=1, addr 0x100, wdata 0xDEADBEEF, wstrb 4'b0010 at T. Expect `mem_we`=4'b0010 and `mem_wdata`=0xDEADBEEF at T, and `lsu_rvalid` at T+2. A subsequent read of 0x100 returns only byte 1 changed, to 0xBE.
- **Contention round-robin, `LATENCY`=1:** both `req` held high for 6 cycles. Grants must follow LSU, IFU, LSU, IFU, LSU, IFU, with one grant every cycle and each `rvalid` one cycle after its grant to the correct owner.
- **Stall while busy, `LATENCY`=3:** grant the IFU at T, then raise `lsu_req` at T+1. `lsu_gnt` must be 0 at T+1 and T+2, and 1 at T+3 in the same cycle as `ifu_rvalid`.
- **Reset mid-operation, `LATENCY`=3:** grant the LSU read at T and assert `rst` at T+1. No `lsu_rvalid` may occur at T+3. After release, a new IFU request is granted immediately.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter between instruction fetch (IFU) and
//               load/store (LSU) ports in front of a single-port memory with
//               a fixed read latency. Tracks the outstanding transaction and
//               steers the memory response back to its owner.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    ifu_req,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr,
    output logic                    ifu_gnt,
    output logic                    ifu_rvalid,
    output logic [DATA_WIDTH-1:0]   ifu_rdata,

    input  logic                    lsu_req,
    input  logic                    lsu_we,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wstrb,
    output logic                    lsu_gnt,
    output logic                    lsu_rvalid,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,

    output logic                    mem_en,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       owner;      // 0 = IFU, 1 = LSU
    logic       last;       // last granted requester, 0 = IFU, 1 = LSU

    logic accept;
    logic pick_lsu;
    logic grant_ifu;
    logic grant_lsu;
    logic resp;

    // Arbitration: a slot opens when idle or in the final cycle of the
    // outstanding transaction, so responses and new grants can overlap.
    always_comb begin
        accept    = (state == IDLE) || ((state == BUSY) && (cnt == 4'd1));
        // On a tie the requester that was not served last wins.
        pick_lsu  = lsu_req && (!ifu_req || (last == 1'b0));
        grant_lsu = !rst && accept && pick_lsu;
        grant_ifu = !rst && accept && ifu_req && !pick_lsu;
        resp      = !rst && (state == BUSY) && (cnt == 4'd1);
    end

    // Memory-side request drive; everything is zero outside a grant cycle.
    always_comb begin
        ifu_gnt   = grant_ifu;
        lsu_gnt   = grant_lsu;
        mem_en    = grant_ifu || grant_lsu;
        mem_addr  = '0;
        mem_we    = '0;
        mem_wdata = '0;
        if (grant_lsu) begin
            mem_addr = lsu_addr;
            if (lsu_we) begin
                mem_we    = lsu_wstrb;
                mem_wdata = lsu_wdata;
            end
        end else if (grant_ifu) begin
            mem_addr = ifu_addr;
        end
    end

    // Response steering: only the owner sees data, the other port reads zero.
    always_comb begin
        ifu_rvalid = resp && !owner;
        lsu_rvalid = resp && owner;
        ifu_rdata  = (resp && !owner) ? mem_rdata : '0;
        lsu_rdata  = (resp && owner)  ? mem_rdata : '0;
    end

    // Transaction tracker: latency countdown, owner and round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            owner <= 1'b0;
            last  <= 1'b0;
        end else if (grant_ifu || grant_lsu) begin
            state <= BUSY;
            cnt   <= LAT;
            owner <= grant_lsu;
            last  <= grant_lsu;
        end else if (state == BUSY) begin
            if (cnt == 4'd1) begin
                state <= IDLE;
                cnt   <= 4'd0;
            end else begin
                cnt   <= cnt - 4'd1;
            end
        end
    end

endmodule
`default_nettype wire
